// File: rtl/vector_reduce_acc_pkg.sv
// Shared types and the reduction operator for the vector reduce/accumulate block.
package vector_reduce_acc_pkg;

  localparam int MAX_DATA_WIDTH = 64;

  typedef enum logic {
    OP_SUM = 1'b0,
    OP_MAX = 1'b1
  } op_e;

  typedef enum logic {
    IDLE_FRAME = 1'b0,
    IN_FRAME   = 1'b1
  } frame_state_e;

  // Operands arrive zero-extended; the low `width` bits are the real value, so MAX
  // sign-extends them before comparing. Callers keep only the low `width` result bits.
  function automatic logic [MAX_DATA_WIDTH-1:0] combine(
    input op_e                       op,
    input logic [MAX_DATA_WIDTH-1:0] a,
    input logic [MAX_DATA_WIDTH-1:0] b,
    input int unsigned               width
  );
    logic signed [MAX_DATA_WIDTH-1:0] sa;
    logic signed [MAX_DATA_WIDTH-1:0] sb;
    int unsigned                      sh;
    sh = MAX_DATA_WIDTH - width;
    sa = signed'(a << sh) >>> sh;
    sb = signed'(b << sh) >>> sh;
    if (op == OP_MAX) begin
      return (sa > sb) ? a : b;
    end
    return a + b;
  endfunction

endpackage

// File: rtl/vector_reduce_acc_reduce_tree.sv
// Pipelined pairwise reduction tree, one register level per halving, with a sideband
// (valid, eof, frame operator) travelling alongside the data.
module reduce_tree
  import vector_reduce_acc_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  eof_in,
  input  op_e                   op_in,
  input  logic [DATA_WIDTH-1:0] vector_in [N-1:0],
  output logic                  valid_out,
  output logic                  eof_out,
  output op_e                   op_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int LEVELS = $clog2(N);

  function automatic logic [DATA_WIDTH-1:0] node_op(
    input op_e                   op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    return DATA_WIDTH'(combine(op, MAX_DATA_WIDTH'(a), MAX_DATA_WIDTH'(b), DATA_WIDTH));
  endfunction

  // Index of the first node of level l in the flattened node space: lanes occupy
  // 0..N-1, the first level's outputs follow at N, and so on up to the root at 2N-2.
  function automatic int level_base(input int l);
    return 2 * N - ((2 * N) >> l);
  endfunction

  logic [DATA_WIDTH-1:0] node_q     [N-1];
  logic [DATA_WIDTH-1:0] node_all   [2*N-1];
  logic [LEVELS-1:0]     valid_q;
  logic [LEVELS-1:0]     eof_q;
  op_e                   op_q       [LEVELS];
  logic [LEVELS:0]       valid_chain;
  logic [LEVELS:0]       eof_chain;
  op_e                   op_chain   [LEVELS+1];

  assign valid_chain = {valid_q, valid_in};
  assign eof_chain   = {eof_q, eof_in};

  always_comb begin
    op_chain[0] = op_in;
    for (int l = 0; l < LEVELS; l++) begin
      op_chain[l+1] = op_q[l];
    end
    for (int i = 0; i < N; i++) begin
      node_all[i] = vector_in[i];
    end
    for (int i = 0; i < N - 1; i++) begin
      node_all[N+i] = node_q[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      eof_q   <= '0;
      for (int l = 0; l < LEVELS; l++) begin
        op_q[l] <= OP_SUM;
      end
      for (int i = 0; i < N - 1; i++) begin
        node_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_chain[LEVELS-1:0];
      eof_q   <= eof_chain[LEVELS-1:0];
      for (int l = 0; l < LEVELS; l++) begin
        op_q[l] <= op_chain[l];
        for (int j = 0; j < (N >> (l + 1)); j++) begin
          node_q[level_base(l+1)-N+j] <= node_op(op_chain[l],
                                                 node_all[level_base(l)+2*j],
                                                 node_all[level_base(l)+2*j+1]);
        end
      end
    end
  end

  assign valid_out = valid_chain[LEVELS];
  assign eof_out   = eof_chain[LEVELS];
  assign op_out    = op_chain[LEVELS];
  assign data_out  = node_all[2*N-2];

endmodule

// File: rtl/vector_reduce_acc.sv
// Frame-wise vector reduction: each vector is tree-reduced, then accumulated until eof,
// reporting the frame result, vector count and operator as a one-cycle pulse.
module vector_reduce_acc
  import vector_reduce_acc_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic                  eof_in,
  input  logic [DATA_WIDTH-1:0] vector_in [N-1:0],
  input  logic                  op_sel,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic [CNT_WIDTH-1:0]  count_out,
  output logic                  op_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                  in_frame_in;
  op_e                   frame_op_q;
  op_e                   tree_op_in;
  logic                  tree_valid;
  logic                  tree_eof;
  op_e                   tree_op;
  logic [DATA_WIDTH-1:0] tree_data;

  frame_state_e          state_q;
  frame_state_e          state_d;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  cnt_next;

  // The operator is captured once, with the first vector of a frame, so the tree and
  // accumulator never see a mid-frame change of op_sel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_frame_in <= 1'b0;
      frame_op_q  <= OP_SUM;
    end else if (valid_in) begin
      if (!in_frame_in) begin
        frame_op_q <= op_e'(op_sel);
      end
      in_frame_in <= !eof_in;
    end
  end

  assign tree_op_in = in_frame_in ? frame_op_q : op_e'(op_sel);

  reduce_tree #(
    .N          (N),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_tree (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .eof_in    (eof_in & valid_in),
    .op_in     (tree_op_in),
    .vector_in (vector_in),
    .valid_out (tree_valid),
    .eof_out   (tree_eof),
    .op_out    (tree_op),
    .data_out  (tree_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE_FRAME;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_next = tree_data;
    cnt_next = CNT_WIDTH'(1);
    if (state_q == IN_FRAME) begin
      acc_next = DATA_WIDTH'(combine(tree_op, MAX_DATA_WIDTH'(acc_q),
                                     MAX_DATA_WIDTH'(tree_data), DATA_WIDTH));
      cnt_next = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
    if (tree_valid) begin
      state_d = tree_eof ? IDLE_FRAME : IN_FRAME;
    end
  end

  // On eof the accumulator and count drop back to their frame-start values so the
  // next frame can follow on the very next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      valid_out  <= 1'b0;
      result_out <= '0;
      count_out  <= '0;
      op_out     <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (tree_valid) begin
        if (tree_eof) begin
          result_out <= acc_next;
          count_out  <= cnt_next;
          op_out     <= tree_op;
          valid_out  <= 1'b1;
          acc_q      <= '0;
          cnt_q      <= '0;
        end else begin
          acc_q <= acc_next;
          cnt_q <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_reduce_acc.sv
// Self-checking bench: directed frames plus random frames against a frame-level model.
module tb_vector_reduce_acc;

  localparam int N   = 8;
  localparam int DW  = 32;
  localparam int CW  = 16;
  localparam int CWS = 2;
  localparam int LAT = $clog2(N) + 1;

  typedef logic [DW-1:0] vec_t [N];

  typedef struct {
    int unsigned    due;
    logic [DW-1:0]  result;
    logic [CW-1:0]  cnt;
    logic [CWS-1:0] cnt_s;
    logic           op;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           valid_in;
  logic           eof_in;
  logic           op_sel;
  logic [DW-1:0]  vector_in [N-1:0];

  logic           valid_out,   valid_out_s;
  logic [DW-1:0]  result_out,  result_out_s;
  logic [CW-1:0]  count_out;
  logic [CWS-1:0] count_out_s;
  logic           op_out,      op_out_s;

  vector_reduce_acc #(.N(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .eof_in(eof_in),
    .vector_in(vector_in), .op_sel(op_sel), .valid_out(valid_out),
    .result_out(result_out), .count_out(count_out), .op_out(op_out)
  );

  vector_reduce_acc #(.N(N), .DATA_WIDTH(DW), .CNT_WIDTH(CWS)) dut_sat (
    .clk(clk), .reset(reset), .valid_in(valid_in), .eof_in(eof_in),
    .vector_in(vector_in), .op_sel(op_sel), .valid_out(valid_out_s),
    .result_out(result_out_s), .count_out(count_out_s), .op_out(op_out_s)
  );

  always #5 clk = ~clk;

  int             checks   = 0;
  int             failures = 0;
  int unsigned    cyc      = 0;
  exp_t           exp_q[$];

  bit             m_in_frame;
  bit             m_op;
  logic [DW-1:0]  m_acc;
  int             m_n;
  logic [DW-1:0]  last_result;
  logic [CW-1:0]  last_cnt;
  logic [CWS-1:0] last_cnt_s;
  logic           last_op;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] laneReduce(input bit op, input vec_t lanes);
    logic [DW-1:0] r;
    if (op) begin
      r = lanes[0];
      for (int i = 1; i < N; i++) if ($signed(lanes[i]) > $signed(r)) r = lanes[i];
    end else begin
      r = '0;
      for (int i = 0; i < N; i++) r = r + lanes[i];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] merge(input bit op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    if (op) return ($signed(a) > $signed(b)) ? a : b;
    return a + b;
  endfunction

  task automatic applyStimulus(input bit v, input bit e, input bit op, input vec_t lanes);
    exp_t x;
    logic [DW-1:0] red;
    @(negedge clk);
    valid_in = v;
    eof_in   = e;
    op_sel   = op;
    for (int i = 0; i < N; i++) vector_in[i] = lanes[i];
    if (v) begin
      if (!m_in_frame) begin
        m_op  = op;
        m_acc = laneReduce(m_op, lanes);
        m_n   = 1;
      end else begin
        red   = laneReduce(m_op, lanes);
        m_acc = merge(m_op, m_acc, red);
        m_n++;
      end
      if (e) begin
        x.due    = cyc + LAT;
        x.result = m_acc;
        x.cnt    = (m_n > 65535) ? CW'(65535) : CW'(m_n);
        x.cnt_s  = (m_n > 3) ? CWS'(3) : CWS'(m_n);
        x.op     = m_op;
        exp_q.push_back(x);
        m_in_frame = 1'b0;
      end else begin
        m_in_frame = 1'b1;
      end
    end
  endtask

  task automatic doReset();
    reset      = 1'b1;
    valid_in   = 1'b0;
    eof_in     = 1'b0;
    m_in_frame = 1'b0;
    exp_q.delete();
    last_result = '0;
    last_cnt    = '0;
    last_cnt_s  = '0;
    last_op     = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_valid_out", valid_out, 0);
    checkOutput("reset_result",    result_out, 0);
    checkOutput("reset_count",     count_out, 0);
    checkOutput("reset_op",        op_out, 0);
    reset = 1'b0;
  endtask

  // Every cycle: either the expected pulse arrives exactly on time, or outputs hold.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      checkOutput("pulse_valid",   valid_out,    1);
      checkOutput("pulse_result",  result_out,   exp_q[0].result);
      checkOutput("pulse_count",   count_out,    exp_q[0].cnt);
      checkOutput("pulse_op",      op_out,       exp_q[0].op);
      checkOutput("sat_valid",     valid_out_s,  1);
      checkOutput("sat_result",    result_out_s, exp_q[0].result);
      checkOutput("sat_count",     count_out_s,  exp_q[0].cnt_s);
      last_result = exp_q[0].result;
      last_cnt    = exp_q[0].cnt;
      last_cnt_s  = exp_q[0].cnt_s;
      last_op     = exp_q[0].op;
      void'(exp_q.pop_front());
    end else begin
      checkOutput("no_pulse",      valid_out,    0);
      checkOutput("sat_no_pulse",  valid_out_s,  0);
      checkOutput("hold_result",   result_out,   last_result);
      checkOutput("hold_count",    count_out,    last_cnt);
      checkOutput("hold_op",       op_out,       last_op);
      checkOutput("sat_hold_count", count_out_s, last_cnt_s);
    end
  end

  initial begin
    vec_t v;
    int   vals [N];
    int   len;
    bit   fop;
    bit   opv;

    reset    = 1'b0;
    valid_in = 1'b0;
    eof_in   = 1'b0;
    op_sel   = 1'b0;
    for (int i = 0; i < N; i++) vector_in[i] = '0;
    #1;
    doReset();

    // single SUM vector 1..8
    for (int i = 0; i < N; i++) v[i] = DW'(i + 1);
    applyStimulus(1, 1, 0, v);
    applyStimulus(0, 0, 0, v);
    repeat (6) applyStimulus(0, 0, 0, v);

    // wrapping SUM over three saturated-looking vectors
    for (int i = 0; i < N; i++) v[i] = 32'h7FFF_FFFF;
    applyStimulus(1, 0, 0, v);
    applyStimulus(1, 0, 1, v);
    applyStimulus(1, 1, 1, v);

    // signed MAX over negatives
    vals = '{-5, -3, -9, -1, -7, -2, -8, -6};
    for (int i = 0; i < N; i++) v[i] = DW'(vals[i]);
    applyStimulus(1, 0, 1, v);
    for (int i = 0; i < N; i++) v[i] = DW'(-4);
    applyStimulus(1, 1, 0, v);

    // back-to-back single-vector frames with different operators
    for (int i = 0; i < N; i++) v[i] = DW'(1);
    applyStimulus(1, 1, 0, v);
    for (int i = 0; i < N; i++) v[i] = DW'(i);
    applyStimulus(1, 1, 1, v);
    repeat (6) applyStimulus(0, 0, 0, v);

    // partial frame discarded by reset
    for (int i = 0; i < N; i++) v[i] = DW'(9);
    applyStimulus(1, 0, 0, v);
    applyStimulus(1, 0, 0, v);
    applyStimulus(0, 0, 0, v);
    doReset();
    for (int i = 0; i < N; i++) v[i] = DW'(2);
    applyStimulus(1, 1, 0, v);
    repeat (6) applyStimulus(0, 0, 0, v);

    // five zero vectors with bubbles: 2-bit count saturates at 3
    for (int i = 0; i < N; i++) v[i] = '0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, k == 4, 0, v);
      if (k < 4) applyStimulus(0, 1, 1, v);
    end
    repeat (6) applyStimulus(0, 0, 0, v);

    // random frames; op_sel toggles mid-frame and must be ignored
    for (int f = 0; f < 30; f++) begin
      len = $urandom_range(1, 6);
      fop = 1'($urandom_range(0, 1));
      for (int k = 0; k < len; k++) begin
        for (int i = 0; i < N; i++) begin
          if (f % 2 == 1) v[i] = $urandom;
          else            v[i] = DW'(int'($urandom_range(0, 40)) - 20);
        end
        opv = (k == 0) ? fop : 1'($urandom_range(0, 1));
        applyStimulus(1, k == len - 1, opv, v);
        if ($urandom_range(0, 3) == 0)
          applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v);
      end
    end
    applyStimulus(0, 0, 0, v);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    checkOutput("drain_pending", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
